// File: rtl/exposure_sequencer_pkg.sv
// Shared definitions for the exposure sequencer: state and status encodings,
// readout modes shared with the readout engine, and the host command code.
package exposure_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_FLUSH_TOG    = 4'd1,
    ST_FLUSH_WAIT   = 4'd2,
    ST_OPEN_SETTLE  = 4'd3,
    ST_EXPOSE       = 4'd4,
    ST_CLOSE_SETTLE = 4'd5,
    ST_READ_TOG     = 4'd6,
    ST_READ_WAIT    = 4'd7,
    ST_FINISH       = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ABORT   = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_t;

  localparam logic [1:0] CCD_MODE_IMAGE = 2'b00;
  localparam logic [1:0] CCD_MODE_FLUSH = 2'b01;

  localparam logic [7:0] CMD_EXPOSE = 8'h20;

  localparam int MS_W = 24;

  function automatic logic is_timed(state_t s);
    return (s == ST_OPEN_SETTLE) || (s == ST_EXPOSE) || (s == ST_CLOSE_SETTLE);
  endfunction

endpackage

// File: rtl/exposure_sequencer_ms_timer.sv
// Millisecond interval timer: TICK_DIV prescaler plus a 24-bit ms down-counter.
// o_expired is high during the final clock cycle of an i_ms * TICK_DIV interval.
module ms_timer
  import exposure_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_count,
  input  logic [MS_W-1:0] i_ms,
  output logic            o_expired
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (i_load) begin
      r_pre <= PRE_MAX;
      r_ms  <= i_ms;
    end else if (i_count) begin
      if (r_pre == '0) begin
        r_pre <= PRE_MAX;
        // Saturate at zero so a stray count can never wrap to 2^24-1.
        if (r_ms != '0) r_ms <= r_ms - 1'b1;
      end else begin
        r_pre <= r_pre - 1'b1;
      end
    end
  end

  assign o_expired = (r_ms == MS_W'(1)) && (r_pre == '0);

endmodule

// File: rtl/exposure_sequencer.sv
// Runs one complete CCD exposure from a single start pulse: optional flush
// readout, shutter open/settle, timed integration, close/settle, image readout.
module exposure_sequencer
  import exposure_sequencer_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int SETTLE_MS    = 200,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [MS_W-1:0] exp_ms,
  input  logic            dark,
  input  logic            flush_en,
  input  logic            ccd_busy,
  output logic            ccd_toggle,
  output logic [1:0]      ccd_mode,
  output logic            shutter_open,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status,
  output logic [3:0]      state_out
);

  localparam int WCNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [MS_W-1:0]   SETTLE_V  = MS_W'(SETTLE_MS);

  state_t            r_state;
  logic [MS_W-1:0]   r_exp_ms;
  logic              r_dark;
  logic              r_abort;
  logic              r_seen_busy;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_tog2;

  state_t            w_nxt;
  logic [1:0]        w_status;
  logic [MS_W-1:0]   w_exp_ms;
  logic              w_dark;
  logic              w_abort;
  logic              w_seen_busy;
  logic [WCNT_W-1:0] w_wcnt;
  logic              w_tog2;
  logic              w_expired;
  logic              w_tmr_load;
  logic [MS_W-1:0]   w_tmr_ms;

  // Zero-length timed states are skipped so the following state is entered directly.
  function automatic state_t skip_empty(state_t s, logic [MS_W-1:0] ms, logic dk);
    state_t t;
    t = s;
    if (t == ST_OPEN_SETTLE && SETTLE_V == '0) t = ST_EXPOSE;
    if (t == ST_EXPOSE && ms == '0) t = dk ? ST_READ_TOG : ST_CLOSE_SETTLE;
    if (t == ST_CLOSE_SETTLE && SETTLE_V == '0) t = ST_READ_TOG;
    return t;
  endfunction

  always_comb begin
    w_nxt       = r_state;
    w_status    = status;
    w_exp_ms    = r_exp_ms;
    w_dark      = r_dark;
    w_abort     = r_abort;
    w_seen_busy = r_seen_busy;
    w_wcnt      = r_wcnt;
    w_tog2      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_exp_ms = exp_ms;
          w_dark   = dark;
          w_abort  = 1'b0;
          w_status = STAT_OK;
          w_nxt    = flush_en ? ST_FLUSH_TOG
                              : skip_empty(dark ? ST_EXPOSE : ST_OPEN_SETTLE, exp_ms, dark);
        end
      end
      ST_FLUSH_TOG, ST_READ_TOG: begin
        if (r_state == ST_FLUSH_TOG && abort) w_abort = 1'b1;
        w_tog2 = ~r_tog2;
        if (r_tog2) begin
          w_nxt       = (r_state == ST_FLUSH_TOG) ? ST_FLUSH_WAIT : ST_READ_WAIT;
          w_seen_busy = 1'b0;
          w_wcnt      = '0;
        end
      end
      ST_FLUSH_WAIT, ST_READ_WAIT: begin
        if (r_state == ST_FLUSH_WAIT && abort) w_abort = 1'b1;
        if (!r_seen_busy) begin
          if (ccd_busy) begin
            w_seen_busy = 1'b1;
          end else if (r_wcnt == WCNT_LAST) begin
            w_nxt    = ST_FINISH;
            w_status = STAT_TIMEOUT;
          end else begin
            w_wcnt = r_wcnt + 1'b1;
          end
        end else if (!ccd_busy) begin
          if (r_state == ST_READ_WAIT) begin
            w_nxt    = ST_FINISH;
            w_status = STAT_OK;
          end else if (r_abort || abort) begin
            w_nxt    = ST_FINISH;
            w_status = STAT_ABORT;
          end else begin
            w_nxt = skip_empty(r_dark ? ST_EXPOSE : ST_OPEN_SETTLE, r_exp_ms, r_dark);
          end
        end
      end
      ST_OPEN_SETTLE, ST_EXPOSE, ST_CLOSE_SETTLE: begin
        if (abort) begin
          w_nxt    = ST_FINISH;
          w_status = STAT_ABORT;
        end else if (w_expired) begin
          if (r_state == ST_OPEN_SETTLE)
            w_nxt = skip_empty(ST_EXPOSE, r_exp_ms, r_dark);
          else if (r_state == ST_EXPOSE)
            w_nxt = skip_empty(r_dark ? ST_READ_TOG : ST_CLOSE_SETTLE, r_exp_ms, r_dark);
          else
            w_nxt = ST_READ_TOG;
        end
      end
      ST_FINISH: w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  assign w_tmr_load = (w_nxt != r_state) && is_timed(w_nxt);
  assign w_tmr_ms   = (w_nxt == ST_EXPOSE) ? w_exp_ms : SETTLE_V;

  ms_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_count   (is_timed(r_state)),
    .i_ms      (w_tmr_ms),
    .o_expired (w_expired)
  );

  // Outputs are registered from the state being entered so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_exp_ms     <= '0;
      r_dark       <= 1'b0;
      r_abort      <= 1'b0;
      r_seen_busy  <= 1'b0;
      r_wcnt       <= '0;
      r_tog2       <= 1'b0;
      ccd_toggle   <= 1'b0;
      ccd_mode     <= CCD_MODE_IMAGE;
      shutter_open <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= STAT_OK;
    end else begin
      r_state      <= w_nxt;
      r_exp_ms     <= w_exp_ms;
      r_dark       <= w_dark;
      r_abort      <= w_abort;
      r_seen_busy  <= w_seen_busy;
      r_wcnt       <= w_wcnt;
      r_tog2       <= w_tog2;
      ccd_toggle   <= (w_nxt == ST_FLUSH_TOG) || (w_nxt == ST_READ_TOG);
      ccd_mode     <= ((w_nxt == ST_FLUSH_TOG) || (w_nxt == ST_FLUSH_WAIT))
                      ? CCD_MODE_FLUSH : CCD_MODE_IMAGE;
      shutter_open <= ((w_nxt == ST_OPEN_SETTLE) || (w_nxt == ST_EXPOSE)) && !w_dark;
      busy         <= (w_nxt != ST_IDLE);
      done         <= (w_nxt == ST_FINISH);
      status       <= w_status;
    end
  end

  assign state_out = r_state;

endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
Sequences one complete CCD exposure: an optional pre-exposure flush readout, shutter open and settle, timed integration, shutter close and settle, then the image readout. It sits between the command state machine and the shutter/readout resources. It replaces ad-hoc open-shutter, wait, close-shutter, toggle-readout command sequences from the host with a single start pulse, giving exact exposure timing in the FPGA.

Parameters:
TICK_DIV, 100000, clk cycles per millisecond tick (100 MHz -> 1 ms)
SETTLE_MS, 200, shutter servo settle time in ms, applied after open and after close
BUSY_TIMEOUT, 16, clk cycles allowed for ccd_busy to rise after a readout toggle

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin an exposure
abort  input  1  single-cycle request to cancel the exposure
exp_ms  input  24  exposure time in ms, latched on accepted start
dark  input  1  keep shutter closed (dark frame), latched on start
flush_en  input  1  run a flush readout before exposing, latched on start
ccd_busy  input  1  readout engine busy
ccd_toggle  output  1  readout trigger, held high for exactly 2 cycles
ccd_mode  output  2  readout mode presented with ccd_toggle
shutter_open  output  1  1 = command shutter open
busy  output  1  sequence in progress (state != IDLE)
done  output  1  1-cycle pulse when the sequence ends
status  output  2  outcome, valid with done: 0 ok, 1 aborted, 2 readout timeout
state_out  output  4  current state, for debug and status readback

Behaviour:
- Reset values: all outputs 0; state IDLE; latched inputs cleared.
- Async reset mid-sequence returns to IDLE immediately. It closes the shutter and drops ccd_toggle, and produces no done pulse.
- States: IDLE, FLUSH_TOG, FLUSH_WAIT, OPEN_SETTLE, EXPOSE, CLOSE_SETTLE, READ_TOG, READ_WAIT, FINISH.
- IDLE: when start=1, latch exp_ms, dark and flush_en. Next state is FLUSH_TOG if flush_en, else OPEN_SETTLE if !dark, else EXPOSE.
- Start while busy is ignored. Abort in IDLE is ignored.
- FLUSH_TOG / READ_TOG: last 2 cycles with ccd_toggle=1. ccd_mode is CCD_MODE_FLUSH or CCD_MODE_IMAGE respectively.
- ccd_mode holds its value from the toggle state through the following WAIT state, and returns to 0 in IDLE.
- FLUSH_WAIT / READ_WAIT, phase 1: wait for ccd_busy=1.
  - If it has not risen within BUSY_TIMEOUT cycles of leaving the toggle state, go to FINISH with status=2.
- FLUSH_WAIT / READ_WAIT, phase 2: wait for ccd_busy=0.
  - From FLUSH_WAIT, continue to OPEN_SETTLE, or to EXPOSE if dark.
  - From READ_WAIT, continue to FINISH with status=0.
- Timed states (OPEN_SETTLE, EXPOSE, CLOSE_SETTLE) last exactly N*TICK_DIV cycles, where N is SETTLE_MS or exp_ms.
  - The prescaler and the ms counter are reloaded on entry to each timed state.
  - N=0 means the state lasts 0 cycles; the next state is entered directly.
  - The ms counter is 24 bits and never wraps; maximum exposure is 2^24-1 ms.
- shutter_open=1 exactly in OPEN_SETTLE and EXPOSE when dark=0; it is 0 in all other states.
- Sequence after EXPOSE: CLOSE_SETTLE if !dark, else READ_TOG. CLOSE_SETTLE is followed by READ_TOG.
- FINISH: done=1 for 1 cycle, then IDLE. busy stays high during FINISH.
- Abort, by state:
  - In FLUSH_TOG, FLUSH_WAIT, OPEN_SETTLE, EXPOSE or CLOSE_SETTLE: shutter_open goes to 0 on the next cycle.
  - If a readout is in flight (toggle issued, ccd_busy not yet low), wait for ccd_busy=0 and time out as above; otherwise go directly to FINISH. Status=1.
  - In READ_TOG or READ_WAIT: abort is ignored, because the image readout completes normally.
- Start and abort in the same IDLE cycle: start wins and abort is ignored.

Decomposition:
- The shared header holds:
  - state encodings;
  - status codes (STAT_OK, STAT_ABORT, STAT_TIMEOUT);
  - CCD_MODE_IMAGE=2'b00 and CCD_MODE_FLUSH=2'b01, shared with the readout engine's header;
  - the new host command code cmd_expose.
- One sub-module: ms_timer. It contains the TICK_DIV prescaler and a 24-bit down-counter, with load/count inputs and an expired output. It is shared by the three timed states.

Test Plan:
All scenarios use TICK_DIV=4, SETTLE_MS=2, BUSY_TIMEOUT=16, and a readout model that raises ccd_busy 3 cycles after the toggle and holds it 10 cycles.
1. start, exp_ms=3, dark=0, flush_en=0 -> shutter_open high for exactly 20 cycles (8+12), starting the cycle after start. ccd_toggle pulses 2 cycles with ccd_mode=0 exactly 8 cycles after shutter falls. done with status=0 follows busy's fall, and busy goes low 1 cycle later.
2. start, dark=1, flush_en=1, exp_ms=5 -> flush toggle with ccd_mode=1, then 20 cycles with shutter_open=0 throughout, then image toggle, then done with status=0.
3. start, exp_ms=0, dark=0 -> shutter_open high for 8 cycles, then close settle, then readout. No EXPOSE cycles occur.
4. abort 5 cycles into EXPOSE -> shutter_open=0 on the next cycle, no ccd_toggle, done with status=1. Separately, abort during READ_WAIT -> readout completes and status=0.
5. Readout model never raises ccd_busy -> done with status=2 exactly 16 cycles after ccd_toggle falls, and shutter_open=0.
6. Second start while busy, plus rst_n asserted mid-EXPOSE -> second start is ignored. On reset all outputs go to 0 asynchronously and there is no done pulse. A start after reset release behaves as in scenario 1.
